psum_drain: RTL and testbench

Output-side accumulator that sits directly downstream of the last `fusion_unit` in a systolic column. It takes the registered `psum_fwd` bus, splits it into 1, 2 or 4 lanes according to the active weight precision, and sign- or zero-extends each lane. It accumulates each lane over a programmable number of beats (the K-dimension tiles) and presents the finished lane sums on a valid/ready output port.

---
 rtl/psum_drain_if.sv | 28 ++
 rtl/psum_drain.sv | 97 +++++++++
 tb/tb_psum_drain.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_drain_if.sv
// psum_drain_if: psum beat input, group configuration and lane-sum result port of psum_drain
interface psum_drain_if #(
    parameter int COL_WIDTH = 13,
    parameter int ACC_WIDTH = 64,
    parameter int LEN_WIDTH = 8
);
    logic [4*COL_WIDTH-1:0] psum_in;
    logic                   psum_valid;
    logic                   psum_ready;
    logic [3:0]             weight_width;
    logic                   s_mode;
    logic [LEN_WIDTH-1:0]   acc_len;
    logic [4*ACC_WIDTH-1:0] out_data;
    logic [3:0]             out_mask;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport master (
        output psum_in, psum_valid, weight_width, s_mode, acc_len, out_ready,
        input  psum_ready, out_data, out_mask, out_valid, busy
    );

    modport slave (
        input  psum_in, psum_valid, weight_width, s_mode, acc_len, out_ready,
        output psum_ready, out_data, out_mask, out_valid, busy
    );
endinterface

// File: rtl/psum_drain.sv
// psum_drain: splits the column psum bus into precision lanes and accumulates each lane over K beats
module psum_drain #(
    parameter int COL_WIDTH = 13,
    parameter int ACC_WIDTH = 64,
    parameter int LEN_WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    psum_drain_if.slave bus
);
    localparam int W = COL_WIDTH;
    localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2;

    logic [1:0]                state;
    logic                      cfg_is8, cfg_is4, cfg_s;
    logic [LEN_WIDTH-1:0]      cfg_len, cnt, cnt_nxt, len;
    logic [3:0][ACC_WIDTH-1:0] acc, lane, sum;
    logic                      first, fire, last, is8, is4, sx;
    logic [3:0]                mask;
    logic [4*W-1:0]            p;
    logic                      unused_ww;

    function automatic logic [ACC_WIDTH-1:0] ext_1(input logic [W-1:0] v, input logic s);
        return {{(ACC_WIDTH-W){s && v[W-1]}}, v};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] ext_2(input logic [2*W-1:0] v, input logic s);
        return {{(ACC_WIDTH-2*W){s && v[2*W-1]}}, v};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] ext_4(input logic [4*W-1:0] v, input logic s);
        return {{(ACC_WIDTH-4*W){s && v[4*W-1]}}, v};
    endfunction

    assign unused_ww      = ^bus.weight_width[1:0];
    assign bus.out_valid  = state == HOLD;
    assign bus.busy       = state == ACC;
    assign bus.psum_ready = !bus.out_valid || bus.out_ready;

    // A group's first beat uses the live configuration; later beats use the latched copy
    always_comb begin
        first   = state != ACC;
        fire    = bus.psum_valid && bus.psum_ready;
        is8     = first ? bus.weight_width[3] : cfg_is8;
        is4     = first ? !bus.weight_width[3] && bus.weight_width[2] : cfg_is4;
        sx      = first ? bus.s_mode : cfg_s;
        len     = first ? (bus.acc_len == '0 ? LEN_WIDTH'(1) : bus.acc_len) : cfg_len;
        cnt_nxt = cnt + LEN_WIDTH'(1);
        last    = (first ? LEN_WIDTH'(1) : cnt_nxt) == len;
        mask    = is8 ? 4'b0001 : is4 ? 4'b0011 : 4'b1111;
    end

    // Unpack lanes by precision, extend to accumulator width and add to the running sums
    always_comb begin
        p       = bus.psum_in;
        lane[0] = is8 ? ext_4(p, sx) : is4 ? ext_2(p[2*W-1:0], sx) : ext_1(p[W-1:0], sx);
        lane[1] = is8 ? '0 : is4 ? ext_2(p[4*W-1:2*W], sx) : ext_1(p[2*W-1:W], sx);
        lane[2] = is8 || is4 ? '0 : ext_1(p[3*W-1:2*W], sx);
        lane[3] = is8 || is4 ? '0 : ext_1(p[4*W-1:3*W], sx);
        for (int i = 0; i < 4; i++) sum[i] = (first ? '0 : acc[i]) + lane[i];
    end

    // Group FSM: latch config on the first beat, accumulate, publish on the final beat, hold until drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            cfg_is8      <= 1'b0;
            cfg_is4      <= 1'b0;
            cfg_s        <= 1'b0;
            cfg_len      <= '0;
            bus.out_data <= '0;
            bus.out_mask <= '0;
        end else if (fire) begin
            if (first) begin
                cfg_is8 <= is8;
                cfg_is4 <= is4;
                cfg_s   <= sx;
                cfg_len <= len;
            end
            if (last) begin
                state        <= HOLD;
                acc          <= '0;
                cnt          <= '0;
                bus.out_data <= sum;
                bus.out_mask <= mask;
            end else begin
                state <= ACC;
                acc   <= sum;
                cnt   <= first ? LEN_WIDTH'(1) : cnt_nxt;
            end
        end else if (state == HOLD && bus.out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: table vectors, directed corner sequences and randomized groups against a lane-sum model
module tb_psum_drain;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    psum_drain_if #(.COL_WIDTH(13), .ACC_WIDTH(64), .LEN_WIDTH(8)) bus ();

    psum_drain #(.COL_WIDTH(13), .ACC_WIDTH(64), .LEN_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [51:0]  p;
        logic [3:0]   ww;
        logic         s;
        logic [255:0] d;
        logic [3:0]   m;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [51:0] p, input logic [3:0] ww, input logic s, input logic [7:0] len);
        bus.psum_in      = p;
        bus.weight_width = ww;
        bus.s_mode       = s;
        bus.acc_len      = len;
        bus.psum_valid   = 1'b1;
    endtask

    function automatic logic [63:0] lane_val(input logic [51:0] p, input logic [3:0] ww, input logic s, input int i);
        int     n;
        int     w;
        longint f;
        n = ww[3] ? 1 : ww[2] ? 2 : 4;
        w = 52 / n;
        if (i >= n) return 64'd0;
        f = longint'((p >> (i * w)) & ((52'd1 << w) - 52'd1));
        if (s && f[w-1]) f = f - (longint'(1) << w);
        return 64'(f);
    endfunction

    function automatic logic [3:0] mask_of(input logic [3:0] ww);
        return ww[3] ? 4'b0001 : ww[2] ? 4'b0011 : 4'b1111;
    endfunction

    initial begin
        logic [3:0]       wws[6];
        logic [3:0][63:0] sums;
        logic [3:0][63:0] m_data;
        logic [3:0]       m_mask;
        logic [3:0]       gww;
        logic             gs;
        logic             m_valid;
        logic             exp_ready;
        logic [7:0]       graw;
        logic [63:0]      rnd;
        int               glen;
        int               taken;
        int               done;
        int               cyc;

        vt[0] = '{52'hF_FFFF_FFFF_FFFB, 4'b1000, 1'b1, {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB}, 4'b0001};
        vt[1] = '{52'hF_FFFF_FFFF_FFFB, 4'b1000, 1'b0, {64'h0, 64'h0, 64'h0, 64'h000F_FFFF_FFFF_FFFB}, 4'b0001};
        vt[2] = '{{26'h200_0000, 26'h000_0005}, 4'b0100, 1'b1, {64'h0, 64'h0, 64'hFFFF_FFFF_FE00_0000, 64'h5}, 4'b0011};
        vt[3] = '{{26'h200_0000, 26'h000_0005}, 4'b0100, 1'b0, {64'h0, 64'h0, 64'h0000_0000_0200_0000, 64'h5}, 4'b0011};
        vt[4] = '{{13'h0007, 13'h1000, 13'h0FFF, 13'h1FFF}, 4'b0010, 1'b0, {64'h7, 64'h1000, 64'hFFF, 64'h1FFF}, 4'b1111};
        vt[5] = '{{13'h0007, 13'h1000, 13'h0FFF, 13'h1FFF}, 4'b0010, 1'b1,
                  {64'h7, 64'hFFFF_FFFF_FFFF_F000, 64'hFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 4'b1111};
        vt[6] = '{52'h0_0000_0000_2001, 4'b0001, 1'b0, {64'h0, 64'h0, 64'h1, 64'h1}, 4'b1111};

        bus.psum_in      = '0;
        bus.psum_valid   = 1'b0;
        bus.weight_width = 4'b1000;
        bus.s_mode       = 1'b0;
        bus.acc_len      = 8'd1;
        bus.out_ready    = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_data", bus.out_data, 0);
        chk("reset out_mask", bus.out_mask, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset psum_ready", bus.psum_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // length-1 vectors back to back: each result appears one edge after its beat
        for (int i = 0; i < 7; i++) begin
            put(vt[i].p, vt[i].ww, vt[i].s, 8'd1);
            tick();
            chk($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
            chk($sformatf("vec%0d data", i), bus.out_data, vt[i].d);
            chk($sformatf("vec%0d mask", i), bus.out_mask, vt[i].m);
        end
        bus.psum_valid = 1'b0;
        tick();
        chk("vec drain out_valid", bus.out_valid, 0);

        // 4b unsigned, three beats
        put({26'd1, 26'd10}, 4'b0100, 1'b0, 8'd3);
        tick();
        chk("len3 busy", bus.busy, 1);
        chk("len3 early out_valid", bus.out_valid, 0);
        put({26'd2, 26'd20}, 4'b0100, 1'b0, 8'd3);
        tick();
        put({26'd3, 26'd30}, 4'b0100, 1'b0, 8'd3);
        tick();
        chk("len3 out_valid", bus.out_valid, 1);
        chk("len3 data", bus.out_data, {64'd0, 64'd0, 64'd6, 64'd60});
        chk("len3 mask", bus.out_mask, 4'b0011);
        chk("len3 busy done", bus.busy, 0);
        bus.psum_valid = 1'b0;
        tick();

        // 2b signed, two beats
        put({13'h0007, 13'h1000, 13'h0FFF, 13'h1FFF}, 4'b0010, 1'b1, 8'd2);
        tick();
        tick();
        chk("2b data", bus.out_data, {64'd14, 64'hFFFF_FFFF_FFFF_E000, 64'd8190, 64'hFFFF_FFFF_FFFF_FFFE});
        chk("2b mask", bus.out_mask, 4'b1111);
        bus.psum_valid = 1'b0;
        tick();

        // backpressure: pending result blocks the next beat, then drain and replace in one edge
        bus.out_ready = 1'b0;
        put(52'd7, 4'b1000, 1'b0, 8'd1);
        tick();
        chk("bp first out_valid", bus.out_valid, 1);
        put(52'd9, 4'b1000, 1'b0, 8'd1);
        #1;
        chk("bp psum_ready low", bus.psum_ready, 0);
        tick();
        chk("bp held out_valid", bus.out_valid, 1);
        chk("bp held data", bus.out_data, 256'd7);
        bus.out_ready = 1'b1;
        #1;
        chk("bp psum_ready high", bus.psum_ready, 1);
        tick();
        chk("bp replace out_valid", bus.out_valid, 1);
        chk("bp replace data", bus.out_data, 256'd9);
        bus.psum_valid = 1'b0;
        tick();
        chk("bp drained", bus.out_valid, 0);

        // configuration changed mid-group is ignored; acc_len 0 means one beat
        put(52'h0_0000_0000_2001, 4'b1000, 1'b0, 8'd2);
        tick();
        put(52'h8_0000_0000_2001, 4'b0001, 1'b1, 8'd5);
        tick();
        chk("cfg out_valid", bus.out_valid, 1);
        chk("cfg data", bus.out_data, {64'd0, 64'd0, 64'd0, 64'h0008_0000_0000_4002});
        chk("cfg mask", bus.out_mask, 4'b0001);
        put({26'd5, 26'd3}, 4'b0100, 1'b0, 8'd0);
        tick();
        chk("len0 out_valid", bus.out_valid, 1);
        chk("len0 data", bus.out_data, {64'd0, 64'd0, 64'd5, 64'd3});
        chk("len0 busy", bus.busy, 0);
        bus.psum_valid = 1'b0;
        tick();

        // reset while holding a result, then reset mid-group
        bus.out_ready = 1'b0;
        put(52'd11, 4'b1000, 1'b0, 8'd1);
        tick();
        bus.psum_valid = 1'b0;
        chk("hold out_valid", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst hold out_valid", bus.out_valid, 0);
        chk("rst hold data", bus.out_data, 0);
        chk("rst hold mask", bus.out_mask, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        put(52'd1, 4'b1000, 1'b0, 8'd4);
        tick();
        tick();
        chk("mid busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst mid busy", bus.busy, 0);
        chk("rst mid psum_ready", bus.psum_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("fresh early out_valid", bus.out_valid, 0);
        tick();
        chk("fresh out_valid", bus.out_valid, 1);
        chk("fresh data", bus.out_data, 256'd4);
        bus.psum_valid = 1'b0;
        tick();

        // randomized groups against the lane-sum model
        wws     = '{4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
        m_valid = 1'b0;
        m_data  = '0;
        m_mask  = '0;
        done    = 0;
        cyc     = 0;
        gww     = wws[$urandom_range(0, 5)];
        gs      = 1'(($urandom));
        graw    = 8'($urandom_range(0, 5));
        glen    = graw == 0 ? 1 : int'(graw);
        taken   = 0;
        sums    = '0;
        while (done < 80 && cyc < 4000) begin
            cyc++;
            chk("rnd out_valid", bus.out_valid, m_valid);
            chk("rnd busy", bus.busy, taken > 0);
            if (m_valid) begin
                chk("rnd data", bus.out_data, m_data);
                chk("rnd mask", bus.out_mask, m_mask);
            end
            rnd            = {$urandom, $urandom};
            bus.psum_in    = rnd[51:0];
            bus.out_ready  = $urandom_range(0, 3) != 0;
            bus.psum_valid = $urandom_range(0, 3) != 0;
            if (taken == 0) begin
                bus.weight_width = gww;
                bus.s_mode       = gs;
                bus.acc_len      = graw;
            end else begin
                bus.weight_width = 4'($urandom);
                bus.s_mode       = 1'($urandom);
                bus.acc_len      = 8'($urandom);
            end
            #1;
            exp_ready = !m_valid || bus.out_ready;
            chk("rnd psum_ready", bus.psum_ready, exp_ready);
            if (bus.psum_valid && exp_ready) begin
                for (int i = 0; i < 4; i++) sums[i] = sums[i] + lane_val(rnd[51:0], gww, gs, i);
                taken++;
            end
            if (taken == glen) begin
                m_valid = 1'b1;
                m_data  = sums;
                m_mask  = mask_of(gww);
                done++;
                gww     = wws[$urandom_range(0, 5)];
                gs      = 1'($urandom);
                graw    = 8'($urandom_range(0, 5));
                glen    = graw == 0 ? 1 : int'(graw);
                taken   = 0;
                sums    = '0;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk("rnd groups completed", done, 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
